// File: rtl/timer_regs_pkg.sv
// Register map, control encodings, FSM states and bus payload shared by the
// timer scheduler and its arbiter.
package timer_regs_pkg;

    localparam int unsigned TMR_ADDR_W = 3;
    localparam int unsigned TMR_DATA_W = 16;

    localparam logic [TMR_ADDR_W-1:0] TMR_STATUS  = 3'd0;
    localparam logic [TMR_ADDR_W-1:0] TMR_CONTROL = 3'd1;
    localparam logic [TMR_ADDR_W-1:0] TMR_PERIODL = 3'd2;
    localparam logic [TMR_ADDR_W-1:0] TMR_PERIODH = 3'd3;
    localparam logic [TMR_ADDR_W-1:0] TMR_SNAPL   = 3'd4;
    localparam logic [TMR_ADDR_W-1:0] TMR_SNAPH   = 3'd5;

    localparam int unsigned CTL_ITO   = 0;
    localparam int unsigned CTL_CONT  = 1;
    localparam int unsigned CTL_START = 2;
    localparam int unsigned CTL_STOP  = 3;

    localparam logic [TMR_DATA_W-1:0] CTL_STOP_VAL    = TMR_DATA_W'(1 << CTL_STOP);
    localparam logic [TMR_DATA_W-1:0] CTL_ONESHOT_VAL =
        TMR_DATA_W'((1 << CTL_START) | (1 << CTL_ITO));

    typedef enum logic [3:0] {
        ST_INIT_STOP = 4'd0,
        ST_INIT_CLR  = 4'd1,
        ST_IDLE      = 4'd2,
        ST_WR_PL     = 4'd3,
        ST_WR_PH     = 4'd4,
        ST_WR_CTL    = 4'd5,
        ST_WAIT_IRQ  = 4'd6,
        ST_ABORT     = 4'd7,
        ST_CLR_TO    = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    typedef struct packed {
        logic                  cs;
        logic [TMR_ADDR_W-1:0] addr;
        logic [TMR_DATA_W-1:0] data;
    } tmr_wr_t;

    function automatic tmr_wr_t tmr_wr(input logic [TMR_ADDR_W-1:0] addr,
                                       input logic [TMR_DATA_W-1:0] data);
        tmr_wr_t w;
        w.cs   = 1'b1;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first unmasked request at or after ptr.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic            found;
    logic [CH_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(ptr) + i) % NUM_CH);
            if (!found && req[idx] && !mask[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_share_sched.sv
// Time-shares one interval timer among NUM_CH one-shot delay requesters,
// programming it over a single-cycle Avalon-MM write master.
module timer_share_sched
    import timer_regs_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH*32-1:0] req_ticks,
    output logic [NUM_CH-1:0]    done,
    output logic                 busy,
    output logic [CH_W-1:0]      active_ch,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);

    localparam int unsigned     TICK_W  = 32;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TICK_W-1:0]   load_q, load_d;
    logic                aborted_q, aborted_d;

    logic [NUM_CH-1:0]   done_q, done_d;
    logic                busy_q, busy_d;
    logic [CH_W-1:0]     active_ch_q, active_ch_d;
    logic [2:0]          tmr_address_q, tmr_address_d;
    logic                tmr_chipselect_q, tmr_chipselect_d;
    logic                tmr_write_n_q, tmr_write_n_d;
    logic [15:0]         tmr_writedata_q, tmr_writedata_d;

    logic [NUM_CH-1:0]   gnt_oh;
    logic [CH_W-1:0]     gnt_idx;
    logic [TICK_W-1:0]   gnt_ticks;
    logic                owner_dropped;
    tmr_wr_t             wr;

    // A channel whose done pulsed last cycle gets one cycle to drop req.
    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (req),
        .mask      (done_q),
        .ptr       (rr_ptr_q),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx)
    );

    always_comb begin
        gnt_ticks = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) begin
                gnt_ticks = gnt_ticks | req_ticks[TICK_W*i +: TICK_W];
            end
        end
    end

    assign owner_dropped = ~req[ch_q];

    // Next-state logic; each state issues at most one timer write.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_ptr_d  = rr_ptr_q;
        load_d    = load_q;
        aborted_d = aborted_q;
        done_d    = '0;
        wr        = '0;
        case (state_q)
            ST_INIT_STOP: begin
                wr      = tmr_wr(TMR_CONTROL, CTL_STOP_VAL);
                state_d = ST_INIT_CLR;
            end
            ST_INIT_CLR: begin
                wr      = tmr_wr(TMR_STATUS, 16'h0000);
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (|gnt_oh) begin
                    ch_d      = gnt_idx;
                    load_d    = gnt_ticks - TICK_W'(1);
                    rr_ptr_d  = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
                    aborted_d = 1'b0;
                    state_d   = (gnt_ticks == '0) ? ST_DONE : ST_WR_PL;
                end
            end
            ST_WR_PL: begin
                wr      = tmr_wr(TMR_PERIODL, load_q[15:0]);
                state_d = owner_dropped ? ST_ABORT : ST_WR_PH;
            end
            ST_WR_PH: begin
                wr      = tmr_wr(TMR_PERIODH, load_q[31:16]);
                state_d = owner_dropped ? ST_ABORT : ST_WR_CTL;
            end
            ST_WR_CTL: begin
                wr      = tmr_wr(TMR_CONTROL, CTL_ONESHOT_VAL);
                state_d = owner_dropped ? ST_ABORT : ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                // Abort takes priority over a coincident irq.
                if (owner_dropped) begin
                    state_d = ST_ABORT;
                end else if (tmr_irq) begin
                    state_d = ST_CLR_TO;
                end
            end
            ST_ABORT: begin
                wr        = tmr_wr(TMR_CONTROL, CTL_STOP_VAL);
                aborted_d = 1'b1;
                state_d   = ST_CLR_TO;
            end
            ST_CLR_TO: begin
                wr      = tmr_wr(TMR_STATUS, 16'h0000);
                state_d = aborted_q ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done_d[ch_q] = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT_STOP;
            end
        endcase
    end

    always_comb begin
        busy_d           = (state_q != ST_IDLE);
        active_ch_d      = ch_q;
        tmr_chipselect_d = wr.cs;
        tmr_write_n_d    = ~wr.cs;
        tmr_address_d    = wr.addr;
        tmr_writedata_d  = wr.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_INIT_STOP;
            ch_q             <= '0;
            rr_ptr_q         <= '0;
            load_q           <= '0;
            aborted_q        <= 1'b0;
            done_q           <= '0;
            busy_q           <= 1'b0;
            active_ch_q      <= '0;
            tmr_address_q    <= '0;
            tmr_chipselect_q <= 1'b0;
            tmr_write_n_q    <= 1'b1;
            tmr_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            ch_q             <= ch_d;
            rr_ptr_q         <= rr_ptr_d;
            load_q           <= load_d;
            aborted_q        <= aborted_d;
            done_q           <= done_d;
            busy_q           <= busy_d;
            active_ch_q      <= active_ch_d;
            tmr_address_q    <= tmr_address_d;
            tmr_chipselect_q <= tmr_chipselect_d;
            tmr_write_n_q    <= tmr_write_n_d;
            tmr_writedata_q  <= tmr_writedata_d;
        end
    end

    assign done           = done_q;
    assign busy           = busy_q;
    assign active_ch      = active_ch_q;
    assign tmr_address    = tmr_address_q;
    assign tmr_chipselect = tmr_chipselect_q;
    assign tmr_write_n    = tmr_write_n_q;
    assign tmr_writedata  = tmr_writedata_q;

endmodule

// File: tb/tb_timer_share_sched.sv
// Bench for timer_share_sched with a behavioural one-shot interval timer,
// a table of single-request vectors and hand-written multi-cycle sequences.
module tb_timer_share_sched;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic [NUM_CH-1:0]    req       = '0;
    logic [NUM_CH*32-1:0] req_ticks = '0;
    logic [NUM_CH-1:0]    done;
    logic                 busy;
    logic [CH_W-1:0]      active_ch;
    logic [2:0]           tmr_address;
    logic                 tmr_chipselect;
    logic                 tmr_write_n;
    logic [15:0]          tmr_writedata;
    logic                 tmr_irq;

    timer_share_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_ticks      (req_ticks),
        .done           (done),
        .busy           (busy),
        .active_ch      (active_ch),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    // Interval timer model with its own state (not reset by the scheduler's reset).
    logic [15:0] t_perl = '0;
    logic [15:0] t_perh = '0;
    logic [31:0] t_cnt  = '0;
    logic        t_run  = 1'b0;
    logic        t_to   = 1'b0;
    logic        t_ito  = 1'b0;

    assign tmr_irq = t_to & t_ito;

    always @(posedge clk) begin
        if (t_run) begin
            if (t_cnt == 32'd0) begin
                t_to  <= 1'b1;
                t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 32'd1;
            end
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito <= tmr_writedata[0];
                    if (tmr_writedata[3]) begin
                        t_run <= 1'b0;
                    end else if (tmr_writedata[2]) begin
                        t_run <= 1'b1;
                        t_cnt <= {t_perh, t_perl};
                    end
                end
                3'd2: t_perl <= tmr_writedata;
                3'd3: t_perh <= tmr_writedata;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t wr_log[$];
    wr_t exp_log[$];
    int  done_cnt [NUM_CH] = '{default: 0};

    always @(negedge clk) begin
        if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
            wr_log.push_back('{a: tmr_address, d: tmr_writedata});
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [2:0] a, input logic [15:0] d);
        exp_log.push_back('{a: a, d: d});
    endtask

    task automatic check_log(input string name);
        check({name, " wr count"}, 32'(wr_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            check($sformatf("%s wr%0d addr", name, i), 32'(wr_log[i].a), 32'(exp_log[i].a));
            check($sformatf("%s wr%0d data", name, i), 32'(wr_log[i].d), 32'(exp_log[i].d));
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
        int r = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Waits up to max_cyc negedges for a done pulse; the requester drops that req bit.
    task automatic wait_done(input int max_cyc, output int ch, output int lat);
        ch  = -1;
        lat = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                ch  = onehot_idx(done);
                lat = n;
                check("done onehot", 32'($countones(done)), 32'd1);
                req = req & ~done;
                break;
            end
        end
        if (ch < 0) check("done timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int          ch;
        logic [31:0] ticks;
        int          lat;
        logic [15:0] pl;
        logic [15:0] ph;
    } vec_t;

    vec_t vecs [6];
    int   order[$];
    int   base [NUM_CH];
    int   got_ch;
    int   got_lat;

    initial begin
        // Latency = negedges from the req-raising negedge to the done pulse: T+8, or 2 for T=0.
        vecs[0] = '{ch: 0, ticks: 32'd10,          lat: 18,    pl: 16'h0009, ph: 16'h0000};
        vecs[1] = '{ch: 1, ticks: 32'd1,           lat: 9,     pl: 16'h0000, ph: 16'h0000};
        vecs[2] = '{ch: 3, ticks: 32'd0,           lat: 2,     pl: 16'h0000, ph: 16'h0000};
        vecs[3] = '{ch: 2, ticks: 32'h0001_0005,   lat: 65549, pl: 16'h0004, ph: 16'h0001};
        vecs[4] = '{ch: 1, ticks: 32'd2,           lat: 10,    pl: 16'h0001, ph: 16'h0000};
        vecs[5] = '{ch: 3, ticks: 32'h0000_0100,   lat: 264,   pl: 16'h00ff, ph: 16'h0000};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst done",       32'(done),           32'd0);
        check("rst busy",       32'(busy),           32'd0);
        check("rst active_ch",  32'(active_ch),      32'd0);
        check("rst chipselect", 32'(tmr_chipselect), 32'd0);
        check("rst write_n",    32'(tmr_write_n),    32'd1);
        check("rst address",    32'(tmr_address),    32'd0);
        check("rst writedata",  32'(tmr_writedata),  32'd0);
        wr_log.delete();
        reset = 1'b0;
        repeat (8) @(negedge clk);
        exp_log.delete();
        exp_push(3'd1, 16'h0008);
        exp_push(3'd0, 16'h0000);
        check_log("init");
        check("init busy", 32'(busy), 32'd0);
        check("init done", 32'(done), 32'd0);
        check("init irq",  32'(tmr_irq), 32'd0);

        // All four channels held with T=3: round-robin order 0,1,2,3,0
        for (int i = 0; i < NUM_CH; i++) req_ticks[32*i +: 32] = 32'd3;
        base = done_cnt;
        order.delete();
        req = 4'hF;
        for (int n = 0; n < 400 && order.size() < 5; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                check("rr onehot", 32'($countones(done)), 32'd1);
                order.push_back(onehot_idx(done));
                if (order.size() == 5) req = '0;
            end
        end
        check("rr grant count", 32'(order.size()), 32'd5);
        for (int k = 0; k < order.size(); k++) begin
            check($sformatf("rr grant %0d", k), 32'(order[k]), 32'(k % 4));
        end
        repeat (5) @(negedge clk);
        check("rr done ch0", 32'(done_cnt[0] - base[0]), 32'd2);
        for (int i = 1; i < NUM_CH; i++) begin
            check($sformatf("rr done ch%0d", i), 32'(done_cnt[i] - base[i]), 32'd1);
        end

        // Single-request vectors
        for (int v = 0; v < 6; v++) begin
            wr_log.delete();
            exp_log.delete();
            req_ticks[32*vecs[v].ch +: 32] = vecs[v].ticks;
            req[vecs[v].ch] = 1'b1;
            wait_done(vecs[v].lat + 20, got_ch, got_lat);
            check($sformatf("v%0d done ch", v),   32'(got_ch),    32'(vecs[v].ch));
            check($sformatf("v%0d latency", v),   32'(got_lat),   32'(vecs[v].lat));
            check($sformatf("v%0d active_ch", v), 32'(active_ch), 32'(vecs[v].ch));
            @(negedge clk);
            check($sformatf("v%0d done width", v), 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            if (vecs[v].ticks != 32'd0) begin
                exp_push(3'd2, vecs[v].pl);
                exp_push(3'd3, vecs[v].ph);
                exp_push(3'd1, 16'h0005);
                exp_push(3'd0, 16'h0000);
            end
            check_log($sformatf("v%0d", v));
            check($sformatf("v%0d irq", v),  32'(tmr_irq), 32'd0);
            check($sformatf("v%0d busy", v), 32'(busy),    32'd0);
        end

        // Abort ch1 mid-wait; ch3 waiting behind it is served next
        wr_log.delete();
        exp_log.delete();
        base = done_cnt;
        req_ticks[32*1 +: 32] = 32'd100;
        req_ticks[32*3 +: 32] = 32'd4;
        req[1] = 1'b1;
        repeat (5) @(negedge clk);
        req[3] = 1'b1;
        repeat (15) @(negedge clk);
        req[1] = 1'b0;
        wait_done(200, got_ch, got_lat);
        check("abort next ch", 32'(got_ch), 32'd3);
        repeat (3) @(negedge clk);
        exp_push(3'd2, 16'd99);
        exp_push(3'd3, 16'h0000);
        exp_push(3'd1, 16'h0005);
        exp_push(3'd1, 16'h0008);
        exp_push(3'd0, 16'h0000);
        exp_push(3'd2, 16'h0003);
        exp_push(3'd3, 16'h0000);
        exp_push(3'd1, 16'h0005);
        exp_push(3'd0, 16'h0000);
        check_log("abort");
        check("abort no done ch1", 32'(done_cnt[1] - base[1]), 32'd0);
        check("abort done ch3",    32'(done_cnt[3] - base[3]), 32'd1);
        check("abort irq",         32'(tmr_irq),               32'd0);

        // Abort in the same cycle as irq (T=1): abort wins, no done
        wr_log.delete();
        exp_log.delete();
        base = done_cnt;
        req_ticks[32*0 +: 32] = 32'd1;
        req[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("race irq high", 32'(tmr_irq), 32'd1);
        req[0] = 1'b0;
        repeat (12) @(negedge clk);
        exp_push(3'd2, 16'h0000);
        exp_push(3'd3, 16'h0000);
        exp_push(3'd1, 16'h0005);
        exp_push(3'd1, 16'h0008);
        exp_push(3'd0, 16'h0000);
        check_log("race");
        check("race no done", 32'(done_cnt[0] - base[0]), 32'd0);
        check("race irq",     32'(tmr_irq),               32'd0);

        // Reset while waiting on the timer: INIT must stop and clear it
        base = done_cnt;
        req_ticks[32*2 +: 32] = 32'd50;
        req[2] = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        req = '0;
        wr_log.delete();
        exp_log.delete();
        repeat (2) @(negedge clk);
        check("midrst busy in reset", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        exp_push(3'd1, 16'h0008);
        exp_push(3'd0, 16'h0000);
        check_log("midrst");
        check("midrst no done", 32'(done_cnt[2] - base[2]), 32'd0);
        check("midrst irq",     32'(tmr_irq),               32'd0);
        check("midrst timer stopped", 32'(t_run),           32'd0);
        check("midrst busy",    32'(busy),                  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
